// File: rtl/font_render_scheduler_if.sv
// Handshake bundle between the font render scheduler, the text buffer and the renderer.
// CURSOR_REDRAW_EN adds the cursor position/move inputs and the render_cursor output.
interface font_render_scheduler_if #(
  parameter int unsigned COLS   = 80,
  parameter int unsigned ROWS   = 30,
  parameter int unsigned GRID_W = 96,
  parameter int unsigned ADDR_W = 20
);
  localparam int unsigned ROW_W   = $clog2(ROWS);
  localparam int unsigned COL_W   = $clog2(COLS);
  localparam int unsigned TADDR_W = $clog2(ROWS * COLS);

  logic               refresh_req;
  logic               cell_valid;
  logic [ROW_W-1:0]   cell_row;
  logic [COL_W-1:0]   cell_col;
  logic               cell_ready;
  logic               text_rd;
  logic [TADDR_W-1:0] text_addr;
  logic [GRID_W-1:0]  text_data;
  logic               text_valid;
  logic               render_start;
  logic [GRID_W-1:0]  render_grid;
  logic [ADDR_W-1:0]  render_base;
  logic               render_done;
  logic               busy;
  logic               frame_done;
`ifdef CURSOR_REDRAW_EN
  logic [ROW_W-1:0]   cursor_row;
  logic [COL_W-1:0]   cursor_col;
  logic               cursor_move;
  logic               render_cursor;
`endif

  // Scheduler side
  modport master (
    input  refresh_req, cell_valid, cell_row, cell_col, text_data, text_valid, render_done,
`ifdef CURSOR_REDRAW_EN
    input  cursor_row, cursor_col, cursor_move,
    output render_cursor,
`endif
    output cell_ready, text_rd, text_addr, render_start, render_grid, render_base, busy, frame_done
  );

  // Environment side (requester, text buffer, renderer)
  modport slave (
    output refresh_req, cell_valid, cell_row, cell_col, text_data, text_valid, render_done,
`ifdef CURSOR_REDRAW_EN
    output cursor_row, cursor_col, cursor_move,
    input  render_cursor,
`endif
    input  cell_ready, text_rd, text_addr, render_start, render_grid, render_base, busy, frame_done
  );
endinterface

// File: rtl/font_render_scheduler.sv
// Walks console cells, fetches each grid record and hands it to the font renderer.
// Optional macro CURSOR_REDRAW_EN enables the cursor old/new cell redraw queue.
module font_render_scheduler #(
  parameter int unsigned COLS    = 80,
  parameter int unsigned ROWS    = 30,
  parameter int unsigned CHAR_W  = 8,
  parameter int unsigned CHAR_H  = 16,
  parameter int unsigned GRID_W  = 96,
  parameter int unsigned ADDR_W  = 20,
  parameter int unsigned FB_BASE = 0
) (
  input logic clk,
  input logic rst_n,
  font_render_scheduler_if.master bus
);
  localparam int unsigned ROW_W   = $clog2(ROWS);
  localparam int unsigned COL_W   = $clog2(COLS);
  localparam int unsigned TADDR_W = $clog2(ROWS * COLS);
  localparam int unsigned ROW_PITCH = CHAR_H * COLS * CHAR_W;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, ARM, WAIT, NEXT} stateT;
  typedef enum logic {SINGLE, SWEEP} modeT;

  stateT              state, stateNext;
  modeT               mode, modeNext;
  logic [ROW_W-1:0]   row, rowNext;
  logic [COL_W-1:0]   col, colNext;
  logic               refreshPending, clrPending, enterFetch, sweepDone, rstDone;
  logic               cellReadyC, cursorQueued;
  logic               textRd, renderStart, busyQ, frameDone;
  logic [TADDR_W-1:0] textAddr;
  logic [ADDR_W-1:0]  renderBase;
  logic [GRID_W-1:0]  renderGrid;
  logic [31:0]        addrFull, baseFull;

`ifdef CURSOR_REDRAW_EN
  logic [ROW_W-1:0] curRow;
  logic [COL_W-1:0] curCol;
  logic [ROW_W-1:0] qRow [2];
  logic [COL_W-1:0] qCol [2];
  logic [1:0]       qCount;
  logic             qPop;
  logic             renderCursor;

  // A move always rewrites the queue with (previous cursor cell, new cursor cell)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      curRow       <= '0;
      curCol       <= '0;
      qRow[0]      <= '0;
      qRow[1]      <= '0;
      qCol[0]      <= '0;
      qCol[1]      <= '0;
      qCount       <= '0;
      renderCursor <= 1'b0;
    end else begin
      if (bus.cursor_move) begin
        qRow[0] <= curRow;
        qCol[0] <= curCol;
        qRow[1] <= bus.cursor_row;
        qCol[1] <= bus.cursor_col;
        qCount  <= 2'd2;
        curRow  <= bus.cursor_row;
        curCol  <= bus.cursor_col;
      end else if (qPop) begin
        qRow[0] <= qRow[1];
        qCol[0] <= qCol[1];
        qCount  <= 2'(qCount - 2'd1);
      end
      renderCursor <= (row == curRow) && (col == curCol);
    end
  end

  assign cursorQueued      = (qCount != 2'd0);
  assign bus.render_cursor = renderCursor;
`else
  assign cursorQueued = 1'b0;
`endif

  // Request acceptance is combinational so a same-cycle refresh can veto it
  assign cellReadyC = rstDone && (state == IDLE) && !refreshPending && !bus.refresh_req && !cursorQueued;

  // Next-state and cell-position logic
  always_comb begin
    stateNext  = state;
    modeNext   = mode;
    rowNext    = row;
    colNext    = col;
    clrPending = 1'b0;
    sweepDone  = 1'b0;
`ifdef CURSOR_REDRAW_EN
    qPop       = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (refreshPending) begin
          modeNext   = SWEEP;
          rowNext    = '0;
          colNext    = '0;
          clrPending = 1'b1;
          stateNext  = FETCH;
`ifdef CURSOR_REDRAW_EN
        end else if (cursorQueued) begin
          qPop = 1'b1;
          if (qRow[0] <= LAST_ROW && qCol[0] <= LAST_COL) begin
            modeNext  = SINGLE;
            rowNext   = qRow[0];
            colNext   = qCol[0];
            stateNext = FETCH;
          end
`endif
        end else if (bus.cell_valid && cellReadyC) begin
          if (bus.cell_row <= LAST_ROW && bus.cell_col <= LAST_COL) begin
            modeNext  = SINGLE;
            rowNext   = bus.cell_row;
            colNext   = bus.cell_col;
            stateNext = FETCH;
          end
        end
      end
      FETCH: if (bus.text_valid) stateNext = ISSUE;
      ISSUE: if (bus.render_done) stateNext = ARM;
      ARM:   stateNext = WAIT;
      WAIT:  if (bus.render_done) stateNext = NEXT;
      NEXT: begin
        if (mode == SINGLE) begin
          stateNext = IDLE;
        end else if (refreshPending) begin
          rowNext    = '0;
          colNext    = '0;
          clrPending = 1'b1;
          stateNext  = FETCH;
        end else if (col < LAST_COL) begin
          colNext   = col + COL_W'(1);
          stateNext = FETCH;
        end else if (row < LAST_ROW) begin
          colNext   = '0;
          rowNext   = row + ROW_W'(1);
          stateNext = FETCH;
        end else begin
          sweepDone = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign enterFetch = (stateNext == FETCH) && (state != FETCH);
  assign addrFull   = 32'(rowNext) * 32'(COLS) + 32'(colNext);
  assign baseFull   = 32'(FB_BASE) + ((32'(rowNext) * 32'(ROW_PITCH) + 32'(colNext) * 32'(CHAR_W)) >> 1);

  // State, position and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      mode           <= SINGLE;
      row            <= '0;
      col            <= '0;
      refreshPending <= 1'b0;
      rstDone        <= 1'b0;
      textRd         <= 1'b0;
      textAddr       <= '0;
      renderBase     <= '0;
      renderGrid     <= '0;
      renderStart    <= 1'b0;
      busyQ          <= 1'b0;
      frameDone      <= 1'b0;
    end else begin
      state   <= stateNext;
      mode    <= modeNext;
      row     <= rowNext;
      col     <= colNext;
      rstDone <= 1'b1;
      if (bus.refresh_req) refreshPending <= 1'b1;
      else if (clrPending) refreshPending <= 1'b0;
      textRd <= (stateNext == FETCH);
      if (enterFetch) begin
        textAddr   <= TADDR_W'(addrFull);
        renderBase <= ADDR_W'(baseFull);
      end
      if (state == FETCH && bus.text_valid) renderGrid <= bus.text_data;
      renderStart <= (state == ISSUE) && bus.render_done;
      busyQ       <= (stateNext != IDLE);
      frameDone   <= sweepDone;
    end
  end

  assign bus.cell_ready   = cellReadyC;
  assign bus.text_rd      = textRd;
  assign bus.text_addr    = textAddr;
  assign bus.render_start = renderStart;
  assign bus.render_grid  = renderGrid;
  assign bus.render_base  = renderBase;
  assign bus.busy         = busyQ;
  assign bus.frame_done   = frameDone;
endmodule

// File: tb/tb_font_render_scheduler.sv
// Scoreboard bench for font_render_scheduler: text-buffer and renderer models plus directed scenarios.
module tb_font_render_scheduler;
  localparam int unsigned ROW_W   = 5;
  localparam int unsigned COL_W   = 7;
  localparam int unsigned TADDR_W = 12;

  typedef struct {
    logic [TADDR_W-1:0] addr;
    logic [19:0]        base;
    logic [95:0]        grid;
  } expT;

  logic clk = 1'b0;
  logic rst_n;
  int   passCnt = 0;
  int   totalCnt = 0;
  int   startCnt = 0;
  int   frameCnt = 0;
  int   doneDelay = 3;
  int   holdCycles = 0;
  int   textLat = 2;
  expT  expQ[$];

  font_render_scheduler_if bus ();

  font_render_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [95:0] gridOf(input int unsigned a);
    return {a * 32'h01010101, 32'hA5A50000 | a, ~a};
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Hand-derived: word address = (row*16*80*8 + col*8)/2 = row*5120 + col*4
  task automatic pushCell(input int r, input int c);
    expT e;
    e.addr = TADDR_W'(r * 80 + c);
    e.base = 20'(r * 5120 + c * 4);
    e.grid = gridOf(r * 80 + c);
    expQ.push_back(e);
  endtask

  task automatic sendCell(input int r, input int c);
    bit ok = 0;
    bus.cell_valid = 1'b1;
    bus.cell_row   = ROW_W'(r);
    bus.cell_col   = COL_W'(c);
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (bus.cell_ready) begin
        @(posedge clk);
        ok = 1;
      end
      @(negedge clk);
    end
    bus.cell_valid = 1'b0;
    if (!ok) check("cell accepted", 96'(bus.cell_ready), 96'(1));
  endtask

  task automatic waitIdle(input int maxCyc);
    repeat (3) @(negedge clk);
    for (int i = 0; i < maxCyc && bus.busy; i++) @(negedge clk);
    check("busy cleared", 96'(bus.busy), 96'(0));
  endtask

  // Text buffer: returns the record textLat cycles after the read strobe
  initial begin
    int cnt = 0;
    bus.text_valid = 1'b0;
    bus.text_data  = '0;
    forever begin
      @(negedge clk);
      if (bus.text_valid) begin
        bus.text_valid = 1'b0;
        cnt = 0;
      end else if (bus.text_rd) begin
        cnt++;
        if (cnt >= textLat) begin
          bus.text_valid = 1'b1;
          bus.text_data  = gridOf(32'(bus.text_addr));
        end
      end
    end
  end

  // Renderer: idle high after its own reset, drops on start, rises doneDelay cycles later
  initial begin
    int cnt = 0;
    int hold = 0;
    bus.render_done = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.render_start) begin
        cnt = 0;
        if (holdCycles > 0) hold = holdCycles;
        else bus.render_done = 1'b0;
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) bus.render_done = 1'b0;
      end else if (!bus.render_done) begin
        cnt++;
        if (cnt >= doneDelay) bus.render_done = 1'b1;
      end
    end
  end

  // Monitor: every start must match the head of the expected queue
  initial begin
    expT e;
    forever begin
      @(negedge clk);
      if (bus.render_start) begin
        startCnt++;
        if (expQ.size() == 0) begin
          check("unexpected start addr", 96'(bus.text_addr), 96'hFFF);
        end else begin
          e = expQ.pop_front();
          check("start text_addr", 96'(bus.text_addr), 96'(e.addr));
          check("start render_base", 96'(bus.render_base), 96'(e.base));
          check("start render_grid", bus.render_grid, e.grid);
        end
      end
      if (bus.frame_done) begin
        frameCnt++;
        check("busy at frame_done", 96'(bus.busy), 96'(0));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exceeded, %0d/%0d checked", passCnt, totalCnt);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, f0, bad;
    rst_n = 1'b0;
    bus.refresh_req = 1'b0;
    bus.cell_valid  = 1'b0;
    bus.cell_row    = '0;
    bus.cell_col    = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 96'(bus.busy), 96'(0));
    check("reset text_rd", 96'(bus.text_rd), 96'(0));
    check("reset render_start", 96'(bus.render_start), 96'(0));
    check("reset frame_done", 96'(bus.frame_done), 96'(0));
    check("reset cell_ready", 96'(bus.cell_ready), 96'(0));
    check("reset render_base", 96'(bus.render_base), 96'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Single cell (2,5): addr 165, base 10260
    s0 = startCnt;
    pushCell(2, 5);
    sendCell(2, 5);
    bad = 0;
    for (int i = 0; i < 50 && bus.busy; i++) begin
      #1;
      if (bus.cell_ready) bad++;
      @(negedge clk);
    end
    check("cell_ready low while busy", 96'(bad), 96'(0));
    waitIdle(50);
    check("single start count", 96'(startCnt - s0), 96'(1));

    // Out-of-range requests are swallowed
    s0 = startCnt;
    sendCell(30, 0);
    sendCell(0, 80);
    repeat (10) @(negedge clk);
    check("out-of-range busy", 96'(bus.busy), 96'(0));
    check("out-of-range starts", 96'(startCnt - s0), 96'(0));

    // Full refresh in raster order
    s0 = startCnt;
    f0 = frameCnt;
    for (int r = 0; r < 30; r++) for (int c = 0; c < 80; c++) pushCell(r, c);
    bus.refresh_req = 1'b1;
    @(negedge clk);
    bus.refresh_req = 1'b0;
    waitIdle(30000);
    check("sweep start count", 96'(startCnt - s0), 96'(2400));
    check("sweep frame_done count", 96'(frameCnt - f0), 96'(1));
    check("sweep queue drained", 96'(expQ.size()), 96'(0));

    // Refresh with simultaneous cell request, then restart at (10,3)
    s0 = startCnt;
    f0 = frameCnt;
    for (int a = 0; a <= 803; a++) pushCell(a / 80, a % 80);
    for (int r = 0; r < 30; r++) for (int c = 0; c < 80; c++) pushCell(r, c);
    bus.refresh_req = 1'b1;
    bus.cell_valid  = 1'b1;
    bus.cell_row    = ROW_W'(0);
    bus.cell_col    = COL_W'(7);
    #1;
    check("cell_ready with refresh", 96'(bus.cell_ready), 96'(0));
    @(negedge clk);
    bus.refresh_req = 1'b0;
    #1;
    check("cell_ready after refresh", 96'(bus.cell_ready), 96'(0));
    @(negedge clk);
    bus.cell_valid = 1'b0;
    for (int i = 0; i < 10000 && !(bus.render_start && bus.text_addr == TADDR_W'(803)); i++) @(negedge clk);
    check("reached cell 10,3", 96'(bus.text_addr), 96'(803));
    bus.refresh_req = 1'b1;
    @(negedge clk);
    bus.refresh_req = 1'b0;
    waitIdle(30000);
    check("abort start count", 96'(startCnt - s0), 96'(3204));
    check("abort frame_done count", 96'(frameCnt - f0), 96'(1));
    check("abort queue drained", 96'(expQ.size()), 96'(0));

    // Renderer keeps done high after start: still one start per cell
    holdCycles = 5;
    s0 = startCnt;
    pushCell(0, 1);
    sendCell(0, 1);
    waitIdle(50);
    repeat (15) @(negedge clk);
    check("held-done start count", 96'(startCnt - s0), 96'(1));
    holdCycles = 0;

    // Reset during WAIT, then restart while renderer is still busy
    doneDelay = 20;
    pushCell(1, 0);
    sendCell(1, 0);
    for (int i = 0; i < 50 && !bus.render_start; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid reset busy", 96'(bus.busy), 96'(0));
    check("mid reset text_rd", 96'(bus.text_rd), 96'(0));
    check("mid reset render_start", 96'(bus.render_start), 96'(0));
    check("mid reset cell_ready", 96'(bus.cell_ready), 96'(0));
    check("mid reset text_addr", 96'(bus.text_addr), 96'(0));
    check("mid reset render_base", 96'(bus.render_base), 96'(0));
    check("mid reset render_grid", bus.render_grid, 96'(0));
    check("renderer still busy", 96'(bus.render_done), 96'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    s0 = startCnt;
    pushCell(0, 2);
    sendCell(0, 2);
    bad = 0;
    for (int i = 0; i < 200 && bus.busy; i++) begin
      @(posedge clk);
      #1;
      if (!bus.render_done && bus.render_start) bad++;
    end
    check("no start while done low", 96'(bad), 96'(0));
    waitIdle(50);
    check("post-reset start count", 96'(startCnt - s0), 96'(1));
    check("post-reset queue drained", 96'(expQ.size()), 96'(0));
    doneDelay = 3;

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
